// File: rtl/adder_ctrl_pkg.sv
// Shared constants and FSM state encoding for the serial adder sequencer.
package adder_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder; one instance serves every chunk of the word.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle Sum = A + B sequencer: one SLICE-bit chunk per clock through a shared slice.
// Build option ACCUMULATE_EN: a Run takes operand A from the current Sum instead of SW.
module serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
  output logic             Done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t           state, state_next;
  logic             run_q, loadb_q;
  logic             run_ev, loadb_ev, start;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout;

  // Buttons are active-low: an event is the high-to-low transition only.
  assign run_ev   = run_q & ~Run;
  assign loadb_ev = loadb_q & ~LoadB;
  assign start    = (state == IDLE) && run_ev && !loadb_ev;
  assign Busy     = (state == ADD);

  assign sl_a = op_a[idx*SLICE +: SLICE];
  assign sl_b = op_b[idx*SLICE +: SLICE];

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (idx == IDX_LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_q   <= 1'b1;
      loadb_q <= 1'b1;
      b_reg   <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      Sum     <= '0;
      CO      <= 1'b0;
      Done    <= 1'b0;
    end else begin
      run_q   <= Run;
      loadb_q <= LoadB;
      Done    <= 1'b0;
      case (state)
        IDLE: begin
          // LoadB wins a tie; the simultaneous Run event is dropped, not deferred.
          if (loadb_ev) begin
            b_reg <= SW;
          end else if (run_ev) begin
            carry <= 1'b0;
            idx   <= '0;
          end
        end
        ADD: begin
          carry <= sl_cout;
          idx   <= idx + IDX_W'(1);
        end
        FIN: begin
          Sum  <= result;
          CO   <= carry;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand snapshot and partial result; Sum only ever sees a completed result.
  always_ff @(posedge Clk) begin
    if (start) begin
`ifdef ACCUMULATE_EN
      op_a <= Sum;
`else
      op_a <= SW;
`endif
      op_b <= b_reg;
    end
    if (state == ADD) result[idx*SLICE +: SLICE] <= sl_s;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (default or ACCUMULATE_EN build).
module tb_serial_adder_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LoadB;
  logic        Run;
  logic [15:0] SW;
  logic [15:0] Sum;
  logic        CO;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadB (LoadB),
    .Run   (Run),
    .SW    (SW),
    .Sum   (Sum),
    .CO    (CO),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] val);
    SW    = val;
    LoadB = 1'b0;
    tick();
    LoadB = 1'b1;
    tick();
  endtask

  // One-cycle Run press, then observe ncyc post-edge samples starting at the event edge.
  task automatic do_run(input logic [15:0] sw, input int ncyc,
                        output int busy_n, output int done_n);
    SW     = sw;
    Run    = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (i == 0) Run = 1'b1;
      busy_n += int'(Busy);
      done_n += int'(Done);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    LoadB = 1'b1;
    Run   = 1'b1;
    SW    = 16'h0000;
    tick();
    tick();
    n_checks++;
    if ({Sum, CO, Busy, Done} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state got Sum=%h CO=%b Busy=%b Done=%b required 0000 0 0 0", Sum, CO, Busy, Done);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int b_n, d_n;
    do_load(16'hfffe);
    do_run(16'h0001, 10, b_n, d_n);
    n_checks++;
    if (Sum !== 16'hffff || CO !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum got %h/%b required ffff/0", Sum, CO);
    end
    n_checks++;
    if (b_n !== 4) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got %0d required 4", b_n);
    end
    n_checks++;
    if (d_n !== 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses got %0d required 1", d_n);
    end
  endtask

  task automatic test_latency();
    int busy_seen = 0;
    // Event edge N; Busy after N..N+3, quiet after N+4, Done and new Sum after N+5.
    SW  = 16'h0002;
    Run = 1'b0;
    tick();
    Run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      busy_seen += int'(Busy);
      if (i < 3) tick();
    end
    tick();
    n_checks++;
    if (busy_seen !== 4 || Busy !== 1'b0 || Done !== 1'b0 || Sum !== 16'hffff) begin
      n_fail++;
      $display("FAIL latency_n4 got busy=%0d Busy=%b Done=%b Sum=%h required 4 0 0 ffff", busy_seen, Busy, Done, Sum);
    end
    tick();
    n_checks++;
    if (Done !== 1'b1 || Sum !== 16'h0000 || CO !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_n5 got Done=%b Sum=%h CO=%b required 1 0000 1", Done, Sum, CO);
    end
    tick();
  endtask

  task automatic test_vectors();
    int b_n, d_n;
    do_load(16'h0ece);
    do_run(16'h0385, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'h1253 || CO !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_0ece_0385 got %h/%b required 1253/0", Sum, CO);
    end
    do_load(16'hffff);
    do_run(16'hffff, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'hfffe || CO !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_ffff_ffff got %h/%b required fffe/1", Sum, CO);
    end
    SW = 16'h1111;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (Sum !== 16'hfffe || CO !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got %h/%b Done=%b required fffe/1 0", Sum, CO, Done);
    end
  endtask

  task automatic test_ignore_busy();
    int d_n = 0;
    int b_n;
    do_load(16'hfffe);
    SW  = 16'h0001;
    Run = 1'b0;
    tick();
    Run = 1'b1;
    d_n += int'(Done);
    tick();
    d_n += int'(Done);
    Run   = 1'b0;
    LoadB = 1'b0;
    SW    = 16'h1234;
    tick();
    d_n += int'(Done);
    Run   = 1'b1;
    LoadB = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      d_n += int'(Done);
    end
    n_checks++;
    if (Sum !== 16'hffff || CO !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_snapshot got %h/%b required ffff/0", Sum, CO);
    end
    n_checks++;
    if (d_n !== 1) begin
      n_fail++;
      $display("FAIL busy_no_requeue got %0d Done pulses required 1", d_n);
    end
    do_run(16'h0000, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'hfffe) begin
      n_fail++;
      $display("FAIL busy_b_stable got %h required fffe", Sum);
    end
  endtask

  task automatic test_hold();
    int d_n = 0;
    int b_n;
    SW  = 16'h0003;
    Run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      d_n += int'(Done);
    end
    Run = 1'b1;
    tick();
    n_checks++;
    if (d_n !== 1 || Sum !== 16'h0001 || CO !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_single got Done=%0d Sum=%h CO=%b required 1 0001 1", d_n, Sum, CO);
    end
    do_run(16'h0005, 8, b_n, d_n);
    n_checks++;
    if (d_n !== 1 || Sum !== 16'h0003 || CO !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_repress got Done=%0d Sum=%h CO=%b required 1 0003 1", d_n, Sum, CO);
    end
  endtask

  task automatic test_same_cycle();
    int d_n = 0;
    int b_n;
    SW    = 16'h0007;
    LoadB = 1'b0;
    Run   = 1'b0;
    tick();
    LoadB = 1'b1;
    Run   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      d_n += int'(Done);
    end
    n_checks++;
    if (d_n !== 0 || Sum !== 16'h0003) begin
      n_fail++;
      $display("FAIL tie_no_add got Done=%0d Sum=%h required 0 0003", d_n, Sum);
    end
    do_run(16'h0001, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'h0008 || CO !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_loadb_won got %h/%b required 0008/0", Sum, CO);
    end
  endtask

  task automatic test_reset_midadd();
    int b_n, d_n;
    SW  = 16'h0001;
    Run = 1'b0;
    tick();
    Run = 1'b1;
    tick();
    tick();
    #2;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (Sum !== 16'h0000 || CO !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got Sum=%h CO=%b Busy=%b Done=%b required 0000 0 0 0", Sum, CO, Busy, Done);
    end
    tick();
    Reset = 1'b1;
    tick();
    do_run(16'h1234, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'h1234 || CO !== 1'b0 || d_n !== 1) begin
      n_fail++;
      $display("FAIL reset_recover got Sum=%h CO=%b Done=%0d required 1234 0 1", Sum, CO, d_n);
    end
  endtask

  task automatic test_accumulate();
    int b_n, d_n;
    logic [15:0] exp_sum [3];
    exp_sum[0] = 16'h0003;
    exp_sum[1] = 16'h0006;
    exp_sum[2] = 16'h0009;
    do_load(16'h0003);
    for (int k = 0; k < 3; k++) begin
      do_run(16'h5555, 8, b_n, d_n);
      n_checks++;
      if (Sum !== exp_sum[k] || CO !== 1'b0 || d_n !== 1) begin
        n_fail++;
        $display("FAIL accum_step%0d got Sum=%h CO=%b Done=%0d required %h 0 1", k, Sum, CO, d_n, exp_sum[k]);
      end
    end
    do_load(16'hfffe);
    do_run(16'h5555, 8, b_n, d_n);
    n_checks++;
    if (Sum !== 16'h0007 || CO !== 1'b1) begin
      n_fail++;
      $display("FAIL accum_wrap got %h/%b required 0007/1", Sum, CO);
    end
  endtask

  initial begin
    test_reset();
`ifdef ACCUMULATE_EN
    test_accumulate();
`else
    test_basic();
    test_latency();
    test_vectors();
    test_ignore_busy();
    test_hold();
    test_same_cycle();
    test_reset_midadd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
